// File: rtl/store_buffer.sv
// store_buffer
//   Write-side formatter and in-order queue for committed stores.
//   Each store (sb/sh/sw/swl/swr) is turned into a word-aligned address,
//   byte strobes and byte-lane-aligned data when it is pushed. Entries
//   drain one at a time to the DCache write port, with at most one write
//   outstanding.
//
// Handshakes:
//   push side : a store is taken on a rising edge where st_valid && st_ready.
//   write side: wr_req stays high with wr_addr/wr_strb/wr_data held stable
//               until the edge that also sees wr_addr_ok. The write
//               completes, and the head entry is released, on the edge that
//               sees wr_data_ok. That can be the same edge as wr_addr_ok.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   st_valid/st_ready    store request handshake
//   st_op[4:0]           one-hot {swr, swl, sw, sh, sb}
//   st_addr, st_data     byte address and rt value of the store
//   wr_req..wr_data      write request to DCache (head entry)
//   wr_addr_ok           DCache accepted the request
//   wr_data_ok           DCache completed the write
//   ld_chk_addr          address of the load currently in MEM
//   ld_conflict          some pending entry targets the same word
//   sb_empty, sb_full    occupancy status
//   dbg_state            drain FSM state (0 idle, 1 req, 2 wait)
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [4:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        wr_req,
    output logic [31:0] wr_addr,
    output logic [3:0]  wr_strb,
    output logic [31:0] wr_data,
    input  logic        wr_addr_ok,
    input  logic        wr_data_ok,
    input  logic [31:0] ld_chk_addr,
    output logic        ld_conflict,
    output logic        sb_empty,
    output logic        sb_full,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t state;

    logic [29:0] ent_addr [DEPTH];
    logic [3:0]  ent_strb [DEPTH];
    logic [31:0] ent_data [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    logic        push;
    logic        pop;
    logic [3:0]  fmt_strb;
    logic [31:0] fmt_data;
    logic [PTR_W-1:0] slot_off;

    assign sb_full   = (count == DEPTH[PTR_W:0]);
    assign st_ready  = !sb_full;
    assign sb_empty  = (count == '0) && (state == S_IDLE);
    assign push      = st_valid && st_ready;
    // The head leaves the queue only when its write completes.
    assign pop       = ((state == S_REQ) && wr_addr_ok && wr_data_ok) ||
                       ((state == S_WAIT) && wr_data_ok);
    assign wr_req    = (state == S_REQ);
    assign dbg_state = state;

    // Outputs are forced to zero outside REQ so that nothing stale (or
    // uninitialised storage after reset) reaches the cache port.
    assign wr_addr = wr_req ? {ent_addr[head], 2'b00} : 32'h0;
    assign wr_strb = wr_req ? ent_strb[head] : 4'h0;
    assign wr_data = wr_req ? ent_data[head] : 32'h0;

    // Lane formatting. swl writes the upper bytes of rt into the low lanes
    // up to and including the addressed byte; swr writes the low bytes of
    // rt from the addressed byte upward. Unknown or multi-hot ops still
    // occupy a slot but write nothing.
    always_comb begin
        fmt_strb = 4'h0;
        fmt_data = 32'h0;
        case (st_op)
            5'b00001: begin
                fmt_strb = 4'b0001 << st_addr[1:0];
                fmt_data = {4{st_data[7:0]}};
            end
            5'b00010: begin
                fmt_strb = st_addr[1] ? 4'b1100 : 4'b0011;
                fmt_data = {2{st_data[15:0]}};
            end
            5'b00100: begin
                fmt_strb = 4'b1111;
                fmt_data = st_data;
            end
            5'b01000: begin
                case (st_addr[1:0])
                    2'd0: begin fmt_strb = 4'b0001; fmt_data = {24'b0, st_data[31:24]}; end
                    2'd1: begin fmt_strb = 4'b0011; fmt_data = {16'b0, st_data[31:16]}; end
                    2'd2: begin fmt_strb = 4'b0111; fmt_data = {8'b0, st_data[31:8]}; end
                    default: begin fmt_strb = 4'b1111; fmt_data = st_data; end
                endcase
            end
            5'b10000: begin
                case (st_addr[1:0])
                    2'd0: begin fmt_strb = 4'b1111; fmt_data = st_data; end
                    2'd1: begin fmt_strb = 4'b1110; fmt_data = {st_data[23:0], 8'b0}; end
                    2'd2: begin fmt_strb = 4'b1100; fmt_data = {st_data[15:0], 16'b0}; end
                    default: begin fmt_strb = 4'b1000; fmt_data = {st_data[7:0], 24'b0}; end
                endcase
            end
            default: begin
                fmt_strb = 4'h0;
                fmt_data = 32'h0;
            end
        endcase
    end

    // Entry storage needs no reset: occupancy is tracked by head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[tail] <= st_addr[31:2];
            ent_strb[tail] <= fmt_strb;
            ent_data[tail] <= fmt_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= S_IDLE;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            case (state)
                S_IDLE: if (count != '0) state <= S_REQ;
                S_REQ:  if (wr_addr_ok) state <= wr_data_ok ? S_IDLE : S_WAIT;
                S_WAIT: if (wr_data_ok) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // A slot is live when its distance from head is below count. The head
    // slot stays live through REQ and WAIT, so in-flight writes still match.
    always_comb begin
        ld_conflict = 1'b0;
        slot_off    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off = PTR_W'(i) - head;
            if (({1'b0, slot_off} < count) && (ent_addr[i] == ld_chk_addr[31:2]))
                ld_conflict = 1'b1;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer
//   Directed scenarios followed by a randomized phase. A behavioural model
//   (a queue of pending writes plus an outstanding flag) is evaluated on
//   every falling edge and checks all status and write-port outputs.
module tb_store_buffer;

    logic        clk;
    logic        resetn;
    logic        st_valid;
    logic        st_ready;
    logic [4:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [3:0]  wr_strb;
    logic [31:0] wr_data;
    logic        wr_addr_ok;
    logic        wr_data_ok;
    logic [31:0] ld_chk_addr;
    logic        ld_conflict;
    logic        sb_empty;
    logic        sb_full;
    logic [1:0]  dbg_state;

    int total;
    int bad;

    // Pending writes in order: {word addr[29:0], strb[3:0], data[31:0]}.
    logic [65:0] exp_q[$];
    logic        inflight;
    logic        gap;

    store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_op      (st_op),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_strb    (wr_strb),
        .wr_data    (wr_data),
        .wr_addr_ok (wr_addr_ok),
        .wr_data_ok (wr_data_ok),
        .ld_chk_addr(ld_chk_addr),
        .ld_conflict(ld_conflict),
        .sb_empty   (sb_empty),
        .sb_full    (sb_full),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Store formatting from byte-lane arithmetic.
    function automatic logic [35:0] fmt(input logic [4:0] op, input logic [1:0] a, input logic [31:0] rt);
        int ai;
        logic [3:0]  s;
        logic [31:0] d;
        ai = int'(a);
        s = 4'h0;
        d = 32'h0;
        case (op)
            5'b00001: begin s = 4'(1 << ai); d = {24'h0, rt[7:0]} * 32'h0101_0101; end
            5'b00010: begin s = 4'(3 << (2 * int'(a[1]))); d = {16'h0, rt[15:0]} * 32'h0001_0001; end
            5'b00100: begin s = 4'hF; d = rt; end
            5'b01000: begin s = 4'((1 << (ai + 1)) - 1); d = rt >> (8 * (3 - ai)); end
            5'b10000: begin s = 4'(15 << ai); d = rt << (8 * ai); end
            default:  begin s = 4'h0; d = 32'h0; end
        endcase
        return {s, d};
    endfunction

    // Evaluated at the falling edge: check outputs against the model, then
    // apply the events the coming rising edge will take.
    task automatic model_check();
        logic hit;
        logic req_m;
        logic push_m;
        logic done;
        logic gap_n;
        if (!resetn) begin
            exp_q.delete();
            inflight = 1'b0;
            gap = 1'b0;
            check("rst_wr_req", 32'(wr_req), 32'd0);
            check("rst_wr_addr", wr_addr, 32'd0);
            check("rst_wr_strb", 32'(wr_strb), 32'd0);
            check("rst_wr_data", wr_data, 32'd0);
            check("rst_empty", 32'(sb_empty), 32'd1);
            check("rst_full", 32'(sb_full), 32'd0);
            check("rst_ready", 32'(st_ready), 32'd1);
            check("rst_conflict", 32'(ld_conflict), 32'd0);
            check("rst_state", 32'(dbg_state), 32'd0);
            return;
        end
        hit = 1'b0;
        foreach (exp_q[i]) if (exp_q[i][65:36] == ld_chk_addr[31:2]) hit = 1'b1;
        req_m = (exp_q.size() > 0) && !inflight && !gap;
        check("ready", 32'(st_ready), 32'(exp_q.size() < 4));
        check("full", 32'(sb_full), 32'(exp_q.size() == 4));
        check("empty", 32'(sb_empty), 32'(exp_q.size() == 0));
        check("conflict", 32'(ld_conflict), 32'(hit));
        check("wr_req", 32'(wr_req), 32'(req_m));
        if (req_m) begin
            check("wr_addr", wr_addr, {exp_q[0][65:36], 2'b00});
            check("wr_strb", 32'(wr_strb), 32'(exp_q[0][35:32]));
            check("wr_data", wr_data, exp_q[0][31:0]);
        end
        done = 1'b0;
        if (req_m && wr_addr_ok) begin
            if (wr_data_ok) done = 1'b1;
            else inflight = 1'b1;
        end else if (inflight && wr_data_ok) begin
            done = 1'b1;
        end
        push_m = st_valid && (exp_q.size() < 4);
        // One idle cycle precedes every request after a completion or after
        // the first store into an empty buffer.
        gap_n = done || ((exp_q.size() == 0) && push_m);
        if (done) begin
            void'(exp_q.pop_front());
            inflight = 1'b0;
        end
        if (push_m) exp_q.push_back({st_addr[31:2], fmt(st_op, st_addr[1:0], st_data)});
        gap = gap_n;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] rt);
        st_valid = 1'b1;
        st_op    = op;
        st_addr  = addr;
        st_data  = rt;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20 && !wr_req; i++) tick();
        check("req_seen", 32'(wr_req), 32'd1);
    endtask

    task automatic drain_one(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        wait_req();
        check("drain_addr", wr_addr, a);
        check("drain_strb", 32'(wr_strb), 32'(s));
        check("drain_data", wr_data, d);
        wr_addr_ok = 1'b1;
        wr_data_ok = 1'b1;
        tick();
        wr_addr_ok = 1'b0;
        wr_data_ok = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        total = 0;
        bad = 0;
        inflight = 1'b0;
        gap = 1'b0;
        resetn = 1'b0;
        st_valid = 1'b0;
        st_op = 5'b0;
        st_addr = 32'h0;
        st_data = 32'h0;
        wr_addr_ok = 1'b0;
        wr_data_ok = 1'b0;
        ld_chk_addr = 32'h0;
        tick();
        tick();
        resetn = 1'b1;

        // Formatting, then back-to-back same-cycle handshakes.
        push(5'b00001, 32'h8000_0003, 32'h1122_3344);
        push(5'b01000, 32'h8000_0011, 32'hAABB_CCDD);
        push(5'b10000, 32'h8000_0022, 32'hAABB_CCDD);
        drain_one(32'h8000_0000, 4'b1000, 32'h4444_4444);
        check("idle_gap", 32'(wr_req), 32'd0);
        tick();
        check("req_after_gap", 32'(wr_req), 32'd1);
        drain_one(32'h8000_0010, 4'b0011, 32'h0000_AABB);
        drain_one(32'h8000_0020, 4'b1100, 32'hCCDD_0000);
        tick();
        check("fmt_empty", 32'(sb_empty), 32'd1);

        // Fill with the handshake held off, then drain with split handshakes.
        for (int k = 0; k < 4; k++) push(5'b00100, 32'h4000_0000 + 32'(4 * k), 32'hC0DE_0000 + 32'(k));
        check("fill_full", 32'(sb_full), 32'd1);
        check("fill_ready", 32'(st_ready), 32'd0);
        push(5'b00100, 32'h4000_0100, 32'hDEAD_BEEF);
        check("fill_still_full", 32'(sb_full), 32'd1);
        for (int k = 0; k < 4; k++) begin
            wait_req();
            check("fill_order", wr_addr, 32'h4000_0000 + 32'(4 * k));
            check("fill_data", wr_data, 32'hC0DE_0000 + 32'(k));
            wr_addr_ok = 1'b1;
            tick();
            wr_addr_ok = 1'b0;
            check("wait_no_req", 32'(wr_req), 32'd0);
            tick();
            wr_data_ok = 1'b1;
            tick();
            wr_data_ok = 1'b0;
            check("post_pop_idle", 32'(wr_req), 32'd0);
        end
        tick();
        check("fill_empty", 32'(sb_empty), 32'd1);

        // Push and pop on the same edge with two entries pending.
        push(5'b00100, 32'h3000_0000, 32'hA0A0_A0A0);
        push(5'b00100, 32'h3000_0004, 32'hB0B0_B0B0);
        wait_req();
        wr_addr_ok = 1'b1;
        tick();
        wr_addr_ok = 1'b0;
        wr_data_ok = 1'b1;
        push(5'b00100, 32'h3000_0008, 32'hC0C0_C0C0);
        wr_data_ok = 1'b0;
        check("pp_not_full", 32'(sb_full), 32'd0);
        check("pp_not_empty", 32'(sb_empty), 32'd0);
        drain_one(32'h3000_0004, 4'hF, 32'hB0B0_B0B0);
        drain_one(32'h3000_0008, 4'hF, 32'hC0C0_C0C0);
        tick();
        check("pp_empty", 32'(sb_empty), 32'd1);

        // Load conflict against a pending halfword store.
        push(5'b00010, 32'h1000_0006, 32'h0000_1234);
        ld_chk_addr = 32'h1000_0004;
        #1;
        check("ld_hit", 32'(ld_conflict), 32'd1);
        ld_chk_addr = 32'h1000_0008;
        #1;
        check("ld_miss", 32'(ld_conflict), 32'd0);
        ld_chk_addr = 32'h1000_0004;
        drain_one(32'h1000_0004, 4'b1100, 32'h1234_1234);
        #1;
        check("ld_after_drain", 32'(ld_conflict), 32'd0);

        // Asynchronous reset while a write is outstanding.
        push(5'b00100, 32'h5000_0000, 32'h1);
        push(5'b00100, 32'h5000_0004, 32'h2);
        push(5'b00100, 32'h5000_0008, 32'h3);
        wait_req();
        wr_addr_ok = 1'b1;
        tick();
        wr_addr_ok = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check("arst_wr_req", 32'(wr_req), 32'd0);
        check("arst_empty", 32'(sb_empty), 32'd1);
        check("arst_full", 32'(sb_full), 32'd0);
        check("arst_ready", 32'(st_ready), 32'd1);
        check("arst_conflict", 32'(ld_conflict), 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        wr_data_ok = 1'b1;
        tick();
        wr_data_ok = 1'b0;
        check("late_ok_empty", 32'(sb_empty), 32'd1);
        push(5'b00001, 32'h6000_0001, 32'h0000_00AB);
        drain_one(32'h6000_0000, 4'b0010, 32'hABAB_ABAB);

        // Randomized traffic; the model checks every cycle.
        for (int c = 0; c < 1500; c++) begin
            int r;
            r = int'($urandom_range(0, 11));
            st_valid = ($urandom_range(0, 1) == 1);
            if (r < 10) st_op = 5'(1 << (r % 5));
            else if (r == 10) st_op = 5'b00000;
            else st_op = 5'b00011;
            st_addr = 32'h2000_0000 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3));
            st_data = $urandom;
            wr_addr_ok = ($urandom_range(0, 2) == 0);
            wr_data_ok = ($urandom_range(0, 2) == 0);
            ld_chk_addr = 32'h2000_0000 + 32'($urandom_range(0, 6) * 4) + 32'($urandom_range(0, 3));
            tick();
        end
        st_valid = 1'b0;
        wr_addr_ok = 1'b1;
        wr_data_ok = 1'b1;
        for (int c = 0; c < 30 && !sb_empty; c++) tick();
        check("final_empty", 32'(sb_empty), 32'd1);
        wr_addr_ok = 1'b0;
        wr_data_ok = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
